// File: rtl/id_exu_src_stage.sv
// id_exu_src_stage: EXU operand select with forwarding, hazard stall and ID/EX register
module id_exu_src_stage #(
    parameter int XLEN      = 64,
    parameter int PC_W      = 32,
    parameter int NBYP      = 3,
    parameter int CONST_INC = 4,
    parameter int CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4:0]           in_rs1,
    input  logic [4:0]           in_rs2,
    input  logic [XLEN-1:0]      in_x_rs1,
    input  logic [XLEN-1:0]      in_x_rs2,
    input  logic [PC_W-1:0]      in_pc,
    input  logic [XLEN-1:0]      in_imm,
    input  logic [XLEN-1:0]      in_csr_r_data,
    input  logic [2:0]           in_src1_sel,
    input  logic [2:0]           in_src2_sel,
    input  logic [NBYP-1:0]      byp_valid,
    input  logic [NBYP*5-1:0]    byp_rd,
    input  logic [NBYP*XLEN-1:0] byp_data,
    input  logic [NBYP-1:0]      byp_data_ok,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_src1,
    output logic [XLEN-1:0]      out_src2,
    output logic [PC_W-1:0]      out_pc,
    output logic [CNT_W-1:0]     stall_cnt
);
    logic [XLEN:0]   f1, f2;
    logic [XLEN-1:0] zext_rs1, src1, src2;
    logic            hz1, hz2, hazard, accept;

    // Returns {not_ready, data}; scanning down lets the youngest matching stage win.
    function automatic logic [XLEN:0] fwd(input logic [4:0] r, input logic [XLEN-1:0] rf);
        logic [XLEN:0] res;
        res = {1'b0, rf};
        for (int i = NBYP - 1; i >= 0; i--)
            if (r != 5'd0 && byp_valid[i] && byp_rd[5*i +: 5] == r)
                res = {!byp_data_ok[i], byp_data[XLEN*i +: XLEN]};
        return res;
    endfunction

    assign f1       = fwd(in_rs1, in_x_rs1);
    assign f2       = fwd(in_rs2, in_x_rs2);
    assign zext_rs1 = XLEN'(in_rs1);

    always_comb begin
        src1 = in_src1_sel == 3'd1 ? f1[XLEN-1:0] :
               in_src1_sel == 3'd2 ? XLEN'(in_pc) :
               in_src1_sel == 3'd3 ? ~f1[XLEN-1:0] :
               in_src1_sel == 3'd4 ? zext_rs1 :
               in_src1_sel == 3'd5 ? ~zext_rs1 : '0;
        src2 = in_src2_sel == 3'd1 ? f2[XLEN-1:0] :
               in_src2_sel == 3'd2 ? in_imm :
               in_src2_sel == 3'd3 ? in_csr_r_data :
               in_src2_sel == 3'd4 ? XLEN'(CONST_INC) : '0;
        hz1 = (in_src1_sel == 3'd1 || in_src1_sel == 3'd3) && f1[XLEN];
        hz2 = in_src2_sel == 3'd1 && f2[XLEN];
    end

    assign hazard   = in_valid && (hz1 || hz2);
    assign in_ready = (!out_valid || out_ready) && !hazard && !flush;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_src1  <= '0;
            out_src2  <= '0;
            out_pc    <= '0;
            stall_cnt <= '0;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (accept) begin
                out_valid <= 1'b1;
                out_src1  <= src1;
                out_src2  <= src2;
                out_pc    <= in_pc;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (hazard && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
        end
    end
endmodule
